mempool_dma_scheduler: RTL and testbench
========================================

# mempool_dma_scheduler

Shares the single cluster DMA frontend among `NumRequesters` independent job sources, such as per-core control register files or a host port. It sits in front of the cluster DMA request spill register and split midend. It arbitrates round-robin, tracks issued jobs in order, and returns a per-requester completion pulse from the `trans_complete` status. It also provides a drain handshake so software can quiesce the DMA before reconfiguration, for example before an RO-cache flush.

## Interface
Parameters:
- `NumRequesters`, default 4: number of job sources; must be ≥ 2.
- `MaxOutstanding`, default 8: jobs issued but not yet complete; power of two, ≥ 2.
- `CntWidth`, default `idx_width(MaxOutstanding+1)`: derived, do not override.

Ports:
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: reset, asynchronous, active-low.
- `req_i` in, `dma_req_t[NumRequesters]`: job descriptor per requester.
- `req_valid_i` in, `[NumRequesters]`: job offered.
- `req_ready_o` out, `[NumRequesters]`: job accepted (grant).
- `dma_req_o` out, `dma_req_t`: registered descriptor to the DMA frontend.
- `dma_req_valid_o` out, 1: descriptor valid.
- `dma_req_ready_i` in, 1: frontend accepts.
- `dma_meta_i` in, `dma_meta_t`: `backend_idle`, plus `trans_complete` (one-cycle pulse per finished job, in issue order).
- `done_o` out, `[NumRequesters]`: one-cycle completion pulse to the owning requester.
- `outstanding_o` out, `[NumRequesters][CntWidth]`: per-requester count of granted, uncompleted jobs.
- `drain_i` in, 1: level; blocks new grants while high.
- `drained_o` out, 1: drain complete.
- `err_o` out, 1: sticky; set on a spurious completion.

## Operation
- Two-state output FSM:
  - IDLE: output register empty.
  - ISSUE: `dma_req_valid_o`=1.
- Grant condition: `!drain_i` && `total_cnt < MaxOutstanding` && (state==IDLE || `dma_req_ready_i`). `total_cnt` is the ID-FIFO fill level before any same-cycle pop.
- Winner is the first valid requester at or after `rr_ptr`, searching with wrap-around. On a grant:
  - `req_ready_o[w]`=1 in the same cycle.
  - `req_i[w]` is captured into `dma_req_o`.
  - `w` is pushed into the ID FIFO and `outstanding[w]` is incremented.
  - `rr_ptr` becomes `(w+1) mod NumRequesters`.
- At most one `req_ready_o` bit is high per cycle.
- IDLE→ISSUE on a grant.
- ISSUE→ISSUE when `dma_req_ready_i` and a new grant occur together (back-to-back).
- ISSUE→IDLE when `dma_req_ready_i` occurs with no grant.
- In ISSUE, `dma_req_o` is stable while `!dma_req_ready_i`.
- On `trans_complete` with the FIFO non-empty:
  - Pop the head ID `h`.
  - `done_o[h]`=1 on the next cycle (registered).
  - Decrement `outstanding[h]`.
- If the same requester has both a push and a pop in one cycle, its count is unchanged.
- On `trans_complete` with the FIFO empty: no pop, `err_o`←1. `err_o` is cleared only by reset.
- `drained_o` = `drain_i` && state==IDLE && FIFO empty && `backend_idle`. It is combinational from registered state plus `drain_i` and `dma_meta_i`.
- Zero-length jobs are forwarded unchanged. The backend reports their completion like any other job.

## Timing
- Reset values:
  - `req_ready_o`=0 (combinational; low during reset)
  - `dma_req_valid_o`=0
  - `dma_req_o`='0
  - `done_o`=0
  - `outstanding_o`=0
  - `err_o`=0
  - `drained_o`: follows its equation (=`drain_i`&&`backend_idle`)
  - `rr_ptr`=0
  - FIFO empty
  - state IDLE
- Latency: grant at cycle t; `dma_req_valid_o` high at t+1. Completion pulse at t_c; `done_o` at t_c+1.
- Throughput: one job per cycle when the frontend is always ready and the FIFO is not full.
- FIFO full: no grant, even if a pop occurs the same cycle. The grant resumes the following cycle.
- Raising `drain_i` while in ISSUE: the held descriptor still completes its handshake; no further grants.
- Reset mid-operation drops all state, including jobs already issued downstream. The integrator resets the DMA together with this block.

## Structure
- `dma_req_t` and `dma_meta_t` are existing `mempool_pkg` types.
- Add `NumDmaRequesters` to `mempool_pkg`.
- The ID FIFO is a natural sub-module: `fifo_v3`, `DEPTH=MaxOutstanding`, `dtype=logic[idx_width(NumRequesters)-1:0]`.
- Round-robin selection lives inline in this module; registers use `registers.svh` macros.

## Test plan
- Single job from requester 2, frontend ready: `req_ready_o`=0b0100 at t, valid at t+1; `trans_complete` at t+5 → `done_o`=0b0100 at t+6, `outstanding_o[2]` back to 0.
- All four requesters valid continuously, frontend ready: grants in order 0,1,2,3,0,…, one per cycle, until 8 are outstanding; the 9th grant occurs only the cycle after the first `trans_complete`.
- `dma_req_ready_i` held low 3 cycles: `dma_req_o` stable, no `req_ready_o` asserted, then handshake and back-to-back grant in the same cycle.
- Jobs issued from requesters 1,3,1 and three completions → `done_o` pulses 0b0010, 0b1000, 0b0010 in order; `outstanding_o[1]` goes 2→1→0.
- `drain_i`=1 with 2 outstanding: no grants; `drained_o` rises only after the 2nd completion with `backend_idle`=1.
- `trans_complete` with the FIFO empty → `err_o`=1, held until reset; reset asserted mid-burst → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/mempool_dma_scheduler_pkg.sv
// Shared types for the cluster DMA job scheduler.
//   dma_req_t        : job descriptor forwarded to the DMA frontend
//   dma_meta_t       : backend status (idle level, per-job completion pulse)
//   sched_state_e    : output register state
//   idx_width()      : index width helper (at least one bit)
package mempool_dma_scheduler_pkg;

  localparam int unsigned NumDmaRequesters = 4;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] num_bytes;
  } dma_req_t;

  typedef struct packed {
    logic backend_idle;
    logic trans_complete;
  } dma_meta_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mempool_dma_scheduler_fifo.sv
// In-order ID FIFO recording which requester owns each issued job.
//   clk_i/rst_ni : clock, async active-low reset
//   push_i/data_i: enqueue (ignored when full)
//   pop_i/data_o : dequeue head (ignored when empty); data_o is the head
//   full_o/empty_o
module mempool_dma_scheduler_fifo
  import mempool_dma_scheduler_pkg::*;
#(
  parameter int unsigned Depth     = 8,
  parameter int unsigned DataWidth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned AddrW  = idx_width(Depth);
  localparam int unsigned UsageW = idx_width(Depth + 1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AddrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [UsageW-1:0]    usage_q;
  logic                 push, pop;

  assign full_o  = (usage_q == UsageW'(Depth));
  assign empty_o = (usage_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      usage_q <= usage_q + UsageW'(push) - UsageW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mempool_dma_scheduler.sv
// Round-robin scheduler sharing one DMA frontend among several job sources.
//   req_i/req_valid_i/req_ready_o : per-requester job offer and grant
//   dma_req_o/_valid_o/_ready_i   : registered descriptor to the frontend
//   dma_meta_i                    : backend_idle + in-order trans_complete
//   done_o                        : one-cycle completion pulse per owner
//   outstanding_o                 : granted-but-uncompleted count per owner
//   drain_i/drained_o             : quiesce request / quiesced indication
//   err_o                         : sticky, completion seen with nothing issued
module mempool_dma_scheduler
  import mempool_dma_scheduler_pkg::*;
#(
  parameter int unsigned NumRequesters  = NumDmaRequesters,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned CntWidth       = idx_width(MaxOutstanding + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  dma_req_t [NumRequesters-1:0]           req_i,
  input  logic [NumRequesters-1:0]               req_valid_i,
  output logic [NumRequesters-1:0]               req_ready_o,
  output dma_req_t                               dma_req_o,
  output logic                                   dma_req_valid_o,
  input  logic                                   dma_req_ready_i,
  input  dma_meta_t                              dma_meta_i,
  output logic [NumRequesters-1:0]               done_o,
  output logic [NumRequesters-1:0][CntWidth-1:0] outstanding_o,
  input  logic                                   drain_i,
  output logic                                   drained_o,
  output logic                                   err_o
);

  localparam int unsigned IdW = idx_width(NumRequesters);

  sched_state_e   state_q;
  logic [IdW-1:0] rr_ptr_q, win, head;
  logic           found, can_grant, grant, pop;
  logic           fifo_full, fifo_empty;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NumRequesters; i++) begin
      idx = (int'(rr_ptr_q) + i) % NumRequesters;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = IdW'(idx);
      end
    end
  end

  // A full FIFO blocks the grant even if a completion pops this cycle.
  assign can_grant = !drain_i && !fifo_full && (state_q == IDLE || dma_req_ready_i);
  assign grant     = rst_ni && can_grant && found;
  assign pop       = dma_meta_i.trans_complete && !fifo_empty;

  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[win] = 1'b1;
  end

  assign drained_o = drain_i && (state_q == IDLE) && fifo_empty && dma_meta_i.backend_idle;

  mempool_dma_scheduler_fifo #(
    .Depth    (MaxOutstanding),
    .DataWidth(IdW)
  ) i_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (grant),
    .data_i (win),
    .pop_i  (pop),
    .data_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      dma_req_o       <= '0;
      dma_req_valid_o <= 1'b0;
      rr_ptr_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_q         <= ISSUE;
            dma_req_valid_o <= 1'b1;
            dma_req_o       <= req_i[win];
          end
        end
        ISSUE: begin
          // Descriptor held until the frontend takes it; a grant in the
          // same cycle refills the register back-to-back.
          if (dma_req_ready_i) begin
            if (grant) begin
              dma_req_o <= req_i[win];
            end else begin
              state_q         <= IDLE;
              dma_req_valid_o <= 1'b0;
            end
          end
        end
        default: begin
          state_q         <= IDLE;
          dma_req_valid_o <= 1'b0;
        end
      endcase
      if (grant) rr_ptr_q <= (win == IdW'(NumRequesters - 1)) ? '0 : win + IdW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_o <= '0;
      err_o  <= 1'b0;
    end else begin
      done_o <= '0;
      if (pop) done_o[head] <= 1'b1;
      if (dma_meta_i.trans_complete && fifo_empty) err_o <= 1'b1;
    end
  end

  // Per-requester counters; push and pop to the same owner cancel out.
  for (genvar r = 0; r < NumRequesters; r++) begin : g_cnt
    logic                inc, dec;
    logic [CntWidth-1:0] cnt_q;
    assign inc = grant && (win == IdW'(r));
    assign dec = pop && (head == IdW'(r));
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_q + CntWidth'(inc) - CntWidth'(dec);
    end
    assign outstanding_o[r] = cnt_q;
  end

endmodule

// File: tb/tb_mempool_dma_scheduler.sv
// Self-checking bench for mempool_dma_scheduler: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_mempool_dma_scheduler;
  import mempool_dma_scheduler_pkg::*;

  localparam int N  = 4;
  localparam int MO = 8;
  localparam int CW = idx_width(MO + 1);

  logic                   clk, rst_n;
  dma_req_t [N-1:0]       req;
  logic [N-1:0]           req_valid, req_ready;
  dma_req_t               dma_req;
  logic                   dma_req_valid, dma_req_ready;
  dma_meta_t              meta;
  logic [N-1:0]           done;
  logic [N-1:0][CW-1:0]   outstanding;
  logic                   drain, drained, err;

  int total = 0;
  int bad   = 0;

  mempool_dma_scheduler #(
    .NumRequesters (N),
    .MaxOutstanding(MO)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .dma_req_o      (dma_req),
    .dma_req_valid_o(dma_req_valid),
    .dma_req_ready_i(dma_req_ready),
    .dma_meta_i     (meta),
    .done_o         (done),
    .outstanding_o  (outstanding),
    .drain_i        (drain),
    .drained_o      (drained),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic dma_req_t rand_desc();
    dma_req_t d;
    d.src       = $urandom;
    d.dst       = $urandom;
    d.num_bytes = $urandom_range(0, 64);
    return d;
  endfunction

  task automatic set_idle();
    req_valid           = '0;
    dma_req_ready       = 1'b1;
    meta.backend_idle   = 1'b1;
    meta.trans_complete = 1'b0;
    drain               = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    for (int i = 0; i < N; i++) req[i] = rand_desc();
    req_valid = '1;
    drain     = 1'b1;
    #2;
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    total++; if (dma_req_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", dma_req_valid); end
    total++; if (dma_req !== '0) begin bad++; $display("FAIL reset_desc: got %h want 0", dma_req); end
    total++; if (done !== '0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (outstanding !== '0) begin bad++; $display("FAIL reset_outstanding: got %h want 0", outstanding); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (drained !== 1'b1) begin bad++; $display("FAIL reset_drained: got %b want 1", drained); end
    @(negedge clk);
    #1;
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready_clocked: got %b want 0", req_ready); end
    set_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    dma_req_t d;
    do_reset();
    d = rand_desc();
    @(negedge clk); req[2] = d; req_valid = 4'b0100; #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    total++; if (dma_req_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", dma_req_valid); end
    total++; if (dma_req !== d) begin bad++; $display("FAIL single_desc: got %h want %h", dma_req, d); end
    total++; if (outstanding[2] !== CW'(1)) begin bad++; $display("FAIL single_out1: got %0d want 1", outstanding[2]); end
    @(negedge clk); #1;
    total++; if (dma_req_valid !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", dma_req_valid); end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); meta.trans_complete = 1'b1;
    @(negedge clk); meta.trans_complete = 1'b0; #1;
    total++; if (done !== 4'b0100) begin bad++; $display("FAIL single_done: got %b want 0100", done); end
    total++; if (outstanding[2] !== CW'(0)) begin bad++; $display("FAIL single_out0: got %0d want 0", outstanding[2]); end
    @(negedge clk); #1;
    total++; if (done !== '0) begin bad++; $display("FAIL single_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_full();
    logic [N-1:0] exp;
    do_reset();
    for (int i = 0; i < N; i++) req[i] = '{src: 32'(i), dst: 32'h0, num_bytes: 32'h0};
    for (int k = 0; k < MO; k++) begin
      @(negedge clk); req_valid = '1; #1;
      exp = '0; exp[k % N] = 1'b1;
      total++; if (req_ready !== exp) begin bad++; $display("FAIL full_grant%0d: got %b want %b", k, req_ready, exp); end
      if (k > 0) begin
        total++; if (dma_req.src !== 32'((k - 1) % N)) begin bad++; $display("FAIL full_desc%0d: got %0d want %0d", k, dma_req.src, (k - 1) % N); end
      end
    end
    @(negedge clk); meta.trans_complete = 1'b1; #1;
    total++; if (req_ready !== '0) begin bad++; $display("FAIL full_block: got %b want 0", req_ready); end
    total++; if (dma_req.src !== 32'(3)) begin bad++; $display("FAIL full_last_desc: got %0d want 3", dma_req.src); end
    for (int i = 0; i < N; i++) begin
      total++; if (outstanding[i] !== CW'(2)) begin bad++; $display("FAIL full_out%0d: got %0d want 2", i, outstanding[i]); end
    end
    @(negedge clk); meta.trans_complete = 1'b0; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL full_resume: got %b want 0001", req_ready); end
    total++; if (done !== 4'b0001) begin bad++; $display("FAIL full_done: got %b want 0001", done); end
    total++; if (outstanding[0] !== CW'(1)) begin bad++; $display("FAIL full_out_pop: got %0d want 1", outstanding[0]); end
    @(negedge clk); req_valid = '0;
  endtask

  task automatic test_back_to_back();
    dma_req_t d0, d1;
    do_reset();
    d0 = rand_desc(); d1 = rand_desc();
    @(negedge clk); req[0] = d0; req[1] = d1; req_valid = 4'b0001; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL b2b_grant0: got %b want 0001", req_ready); end
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); req_valid = 4'b0010; dma_req_ready = 1'b0; #1;
      total++; if (req_ready !== '0) begin bad++; $display("FAIL b2b_stall_ready%0d: got %b want 0", s, req_ready); end
      total++; if (dma_req !== d0 || dma_req_valid !== 1'b1) begin bad++; $display("FAIL b2b_stall_desc%0d: got %h/%b want %h/1", s, dma_req, dma_req_valid, d0); end
    end
    @(negedge clk); dma_req_ready = 1'b1; #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL b2b_grant1: got %b want 0010", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    total++; if (dma_req !== d1 || dma_req_valid !== 1'b1) begin bad++; $display("FAIL b2b_desc1: got %h/%b want %h/1", dma_req, dma_req_valid, d1); end
    @(negedge clk); #1;
    total++; if (dma_req_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", dma_req_valid); end
  endtask

  task automatic test_order();
    do_reset();
    for (int i = 0; i < N; i++) req[i] = rand_desc();
    @(negedge clk); req_valid = 4'b0010; #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL order_g0: got %b want 0010", req_ready); end
    @(negedge clk); req_valid = 4'b1000; #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL order_g1: got %b want 1000", req_ready); end
    @(negedge clk); req_valid = 4'b0010; #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL order_g2: got %b want 0010", req_ready); end
    @(negedge clk); req_valid = '0; meta.trans_complete = 1'b1; #1;
    total++; if (outstanding[1] !== CW'(2) || outstanding[3] !== CW'(1)) begin bad++; $display("FAIL order_counts: got %0d/%0d want 2/1", outstanding[1], outstanding[3]); end
    @(negedge clk); #1;
    total++; if (done !== 4'b0010 || outstanding[1] !== CW'(1)) begin bad++; $display("FAIL order_d0: got %b/%0d want 0010/1", done, outstanding[1]); end
    @(negedge clk); #1;
    total++; if (done !== 4'b1000 || outstanding[3] !== CW'(0)) begin bad++; $display("FAIL order_d1: got %b/%0d want 1000/0", done, outstanding[3]); end
    @(negedge clk); meta.trans_complete = 1'b0; #1;
    total++; if (done !== 4'b0010 || outstanding[1] !== CW'(0)) begin bad++; $display("FAIL order_d2: got %b/%0d want 0010/0", done, outstanding[1]); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL order_err: got %b want 0", err); end
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < N; i++) req[i] = rand_desc();
    @(negedge clk); req_valid = 4'b0001; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL drain_g0: got %b want 0001", req_ready); end
    @(negedge clk); req_valid = 4'b0010; #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL drain_g1: got %b want 0010", req_ready); end
    @(negedge clk); req_valid = '1; drain = 1'b1; #1;
    total++; if (req_ready !== '0 || drained !== 1'b0) begin bad++; $display("FAIL drain_issue: got %b/%b want 0000/0", req_ready, drained); end
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); #1;
      total++; if (req_ready !== '0 || drained !== 1'b0) begin bad++; $display("FAIL drain_hold%0d: got %b/%b want 0000/0", s, req_ready, drained); end
    end
    @(negedge clk); meta.trans_complete = 1'b1; #1;
    @(negedge clk); #1;
    total++; if (drained !== 1'b0) begin bad++; $display("FAIL drain_one_left: got %b want 0", drained); end
    @(negedge clk); meta.trans_complete = 1'b0; #1;
    total++; if (drained !== 1'b1 || req_ready !== '0) begin bad++; $display("FAIL drain_done: got %b/%b want 1/0000", drained, req_ready); end
    meta.backend_idle = 1'b0; #1;
    total++; if (drained !== 1'b0) begin bad++; $display("FAIL drain_busy_backend: got %b want 0", drained); end
    meta.backend_idle = 1'b1;
  endtask

  task automatic test_err();
    do_reset();
    @(negedge clk); meta.trans_complete = 1'b1; #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_early: got %b want 0", err); end
    @(negedge clk); meta.trans_complete = 1'b0; #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err); end
    repeat (5) @(negedge clk);
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
    for (int i = 0; i < N; i++) req[i] = rand_desc();
    req_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (outstanding === '0) begin bad++; $display("FAIL err_burst: got %h want nonzero", outstanding); end
    #1; rst_n = 1'b0; #1;
    total++; if (dma_req_valid !== 1'b0 || dma_req !== '0) begin bad++; $display("FAIL async_rst_out: got %b/%h want 0/0", dma_req_valid, dma_req); end
    total++; if (outstanding !== '0 || done !== '0) begin bad++; $display("FAIL async_rst_cnt: got %h/%b want 0/0", outstanding, done); end
    total++; if (err !== 1'b0 || req_ready !== '0) begin bad++; $display("FAIL async_rst_err: got %b/%b want 0/0", err, req_ready); end
    set_idle();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_random();
    int           q[$];
    int           cnt[N];
    int           rr, w, h;
    bit           hv, exp_err;
    dma_req_t     held;
    logic [N-1:0] exp_done, exp_ready;
    logic         exp_drained;
    do_reset();
    q = {}; rr = 0; hv = 0; exp_err = 0; exp_done = '0; held = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      total++; if (dma_req_valid !== hv) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, dma_req_valid, hv); end
      if (hv) begin
        total++; if (dma_req !== held) begin bad++; $display("FAIL rnd_desc@%0d: got %h want %h", c, dma_req, held); end
      end
      total++; if (done !== exp_done) begin bad++; $display("FAIL rnd_done@%0d: got %b want %b", c, done, exp_done); end
      for (int i = 0; i < N; i++) begin
        total++; if (outstanding[i] !== CW'(cnt[i])) begin bad++; $display("FAIL rnd_out%0d@%0d: got %0d want %0d", i, c, outstanding[i], cnt[i]); end
      end
      total++; if (err !== exp_err) begin bad++; $display("FAIL rnd_err@%0d: got %b want %b", c, err, exp_err); end
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req[i] = rand_desc();
      dma_req_ready       = ($urandom_range(3) != 0);
      drain               = ($urandom_range(15) == 0);
      meta.backend_idle   = 1'($urandom_range(1));
      meta.trans_complete = (q.size() > 0) ? ($urandom_range(2) == 0) : ($urandom_range(300) == 0);
      #1;
      w = -1;
      if (!drain && q.size() < MO && (!hv || dma_req_ready))
        for (int i = 0; i < N; i++)
          if (w < 0 && req_valid[(rr + i) % N]) w = (rr + i) % N;
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      exp_drained = drain && !hv && (q.size() == 0) && meta.backend_idle;
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", c, req_ready, exp_ready); end
      total++; if (drained !== exp_drained) begin bad++; $display("FAIL rnd_drained@%0d: got %b want %b", c, drained, exp_drained); end
      exp_done = '0;
      if (meta.trans_complete) begin
        if (q.size() > 0) begin
          h = q.pop_front();
          exp_done[h] = 1'b1;
          cnt[h]--;
        end else begin
          exp_err = 1'b1;
        end
      end
      if (w >= 0) begin
        q.push_back(w);
        cnt[w]++;
        held = req[w];
        hv   = 1'b1;
        rr   = (w + 1) % N;
      end else if (hv && dma_req_ready) begin
        hv = 1'b0;
      end
    end
  endtask

  initial begin
    set_idle();
    req = '0;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_order();
    test_drain();
    test_err();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

endmodule
